// File: rtl/reg_access_pkg.sv
// Shared types and constants for the register-file access controller.
// Widths match the 8-entry, 8-bit register file this block drives.
package reg_access_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 3;

  // Address 0 reads as zero and ignores writes.
  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HOLD
  } state_e;

endpackage

// File: rtl/reg_access_ctrl_if.sv
// Writeback, operand-fetch, operand-response and register-file port bundle.
// master = requester/register-file side, slave = reg_access_ctrl.
interface reg_access_ctrl_if;
  import reg_access_pkg::*;

  logic              wb_valid;
  logic              wb_ready;
  logic [ADDR_W-1:0] wb_rd;
  logic [DATA_W-1:0] wb_data;

  logic              rd_valid;
  logic              rd_ready;
  logic [ADDR_W-1:0] rd_rs;
  logic [ADDR_W-1:0] rd_rt;

  logic              op_valid;
  logic              op_ready;
  logic [DATA_W-1:0] op_rs_data;
  logic [DATA_W-1:0] op_rt_data;

  logic              rf_rw;
  logic [ADDR_W-1:0] rf_rs;
  logic [ADDR_W-1:0] rf_rt;
  logic [ADDR_W-1:0] rf_rd;
  logic [DATA_W-1:0] rf_rd_data;
  logic [DATA_W-1:0] rf_rs_data;
  logic [DATA_W-1:0] rf_rt_data;

  modport master (
    output wb_valid, wb_rd, wb_data, input wb_ready,
    output rd_valid, rd_rs, rd_rt, input rd_ready,
    input  op_valid, op_rs_data, op_rt_data, output op_ready,
    input  rf_rw, rf_rs, rf_rt, rf_rd, rf_rd_data,
    output rf_rs_data, rf_rt_data
  );

  modport slave (
    input  wb_valid, wb_rd, wb_data, output wb_ready,
    input  rd_valid, rd_rs, rd_rt, output rd_ready,
    output op_valid, op_rs_data, op_rt_data, input op_ready,
    output rf_rw, rf_rs, rf_rt, rf_rd, rf_rd_data,
    input  rf_rs_data, rf_rt_data
  );

endinterface

// File: rtl/reg_access_starve_ctr.sv
// Saturating count of cycles a ready-to-issue read lost to a write.
// hit is taken straight from the count register, so it has no input-to-output path.
module reg_access_starve_ctr #(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam int CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q, cnt_d;

  // NOTE: cnt_d is given its hold value before any branch, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && (cnt_q != LIMIT)) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign hit = (cnt_q == LIMIT);

endmodule

// File: rtl/reg_access_ctrl.sv
// Merges writeback and operand-fetch traffic onto the register file's single port set
// and returns each captured operand pair on a valid/ready channel.
module reg_access_ctrl
  import reg_access_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic               clk,
  input  logic               reset,
  reg_access_ctrl_if.slave   bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] op_rs_q, op_rs_d;
  logic [DATA_W-1:0] op_rt_q, op_rt_d;

  logic throttle;
  logic wb_ready_w;
  logic wr_en;
  logic rd_permit;
  logic rd_ready_w;
  logic rd_fire;

  // A write owns the port for its cycle; reads wait unless the starvation throttle holds writes off.
  assign wb_ready_w = !reset && !throttle;
  assign wr_en      = bus.wb_valid && wb_ready_w && (bus.wb_rd != REG_ZERO);
  assign rd_permit  = !reset && ((state_q == IDLE) || ((state_q == HOLD) && bus.op_ready));
  assign rd_ready_w = rd_permit && !wr_en;
  assign rd_fire    = bus.rd_valid && rd_ready_w;

  reg_access_starve_ctr #(.STARVE_LIMIT(STARVE_LIMIT)) u_starve (
    .clk   (clk),
    .reset (reset),
    .inc   (bus.rd_valid && rd_permit && wr_en),
    .clr   (rd_fire || throttle),
    .hit   (throttle)
  );

  assign bus.wb_ready   = wb_ready_w;
  assign bus.rd_ready   = rd_ready_w;
  assign bus.rf_rw      = wr_en;
  assign bus.rf_rd      = wr_en   ? bus.wb_rd   : '0;
  assign bus.rf_rd_data = wr_en   ? bus.wb_data : '0;
  assign bus.rf_rs      = rd_fire ? bus.rd_rs   : '0;
  assign bus.rf_rt      = rd_fire ? bus.rd_rt   : '0;

  assign bus.op_valid   = (state_q == HOLD);
  assign bus.op_rs_data = op_rs_q;
  assign bus.op_rt_data = op_rt_q;

  always_comb begin
    state_d = state_q;
    op_rs_d = op_rs_q;
    op_rt_d = op_rt_q;
    unique case (state_q)
      IDLE: if (rd_fire) state_d = FETCH;
      FETCH: begin
        // File outputs now carry the data addressed in the accept cycle.
        op_rs_d = bus.rf_rs_data;
        op_rt_d = bus.rf_rt_data;
        state_d = HOLD;
      end
      HOLD: if (bus.op_ready) state_d = rd_fire ? FETCH : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      op_rs_q <= '0;
      op_rt_q <= '0;
    end else begin
      state_q <= state_d;
      op_rs_q <= op_rs_d;
      op_rt_q <= op_rt_d;
    end
  end

endmodule

// File: tb/tb_reg_access_ctrl.sv
// Directed bench for reg_access_ctrl with a behavioural register file and
// a per-cycle transaction-level model of the expected port activity.
module tb_reg_access_ctrl;
  import reg_access_pkg::*;

  localparam int STARVE_LIMIT = 4;
  localparam int NREG = 1 << ADDR_W;
  localparam int BUDGET = 20;

  logic clk = 1'b0;
  logic reset = 1'b1;

  reg_access_ctrl_if bus();

  reg_access_ctrl #(.STARVE_LIMIT(STARVE_LIMIT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Register file: synchronous reset, write suppresses read, read data one clock after address.
  logic [DATA_W-1:0] rf_mem [NREG];
  logic [DATA_W-1:0] rf_rs_q, rf_rt_q;

  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) rf_mem[i] <= '0;
      rf_rs_q <= '0;
      rf_rt_q <= '0;
    end else if (bus.rf_rw) begin
      if (bus.rf_rd != REG_ZERO) rf_mem[bus.rf_rd] <= bus.rf_rd_data;
    end else begin
      rf_rs_q <= rf_mem[bus.rf_rs];
      rf_rt_q <= rf_mem[bus.rf_rt];
    end
  end

  assign bus.rf_rs_data = rf_rs_q;
  assign bus.rf_rt_data = rf_rt_q;

  // Hand-computed response values, in handshake order.
  typedef struct packed {
    logic [DATA_W-1:0] rs;
    logic [DATA_W-1:0] rt;
  } pair_t;

  pair_t lit_mem [16];
  int    lit_wr  = 0;
  int    tmo_cnt = 0;
  bit    done    = 1'b0;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Model state: architectural register contents plus the in-flight / held response.
  logic [DATA_W-1:0] m_regs [NREG];
  bit                m_fetch = 1'b0;
  bit                m_valid = 1'b0;
  logic [DATA_W-1:0] m_f_rs = '0, m_f_rt = '0;
  logic [DATA_W-1:0] m_rs = '0, m_rt = '0;
  int                m_cnt = 0;
  int                lit_rd = 0;

  initial for (int i = 0; i < NREG; i++) m_regs[i] = '0;

  always @(negedge clk) begin
    logic e_wb_ready, e_rw, e_permit, e_rd_ready, e_rfire, idle;

    idle       = !m_fetch && !m_valid;
    e_wb_ready = !reset && (m_cnt != STARVE_LIMIT);
    e_rw       = bus.wb_valid && e_wb_ready && (bus.wb_rd != 0);
    e_permit   = !reset && (idle || (m_valid && bus.op_ready));
    e_rd_ready = e_permit && !e_rw;
    e_rfire    = bus.rd_valid && e_rd_ready;

    check("wb_ready",   bus.wb_ready,   e_wb_ready);
    check("rd_ready",   bus.rd_ready,   e_rd_ready);
    check("rf_rw",      bus.rf_rw,      e_rw);
    check("rf_rd",      bus.rf_rd,      e_rw ? bus.wb_rd : 3'd0);
    check("rf_rd_data", bus.rf_rd_data, e_rw ? bus.wb_data : 8'd0);
    check("rf_rs",      bus.rf_rs,      e_rfire ? bus.rd_rs : 3'd0);
    check("rf_rt",      bus.rf_rt,      e_rfire ? bus.rd_rt : 3'd0);
    check("op_valid",   bus.op_valid,   m_valid && !reset);
    check("op_rs_data", bus.op_rs_data, reset ? 8'd0 : m_rs);
    check("op_rt_data", bus.op_rt_data, reset ? 8'd0 : m_rt);

    if (!reset && bus.op_valid && bus.op_ready) begin
      if (lit_rd < lit_wr) begin
        check("lit_rs", bus.op_rs_data, lit_mem[lit_rd].rs);
        check("lit_rt", bus.op_rt_data, lit_mem[lit_rd].rt);
        lit_rd++;
      end else begin
        check("lit_pending", lit_wr - lit_rd, 1);
      end
    end

    if (reset) begin
      m_fetch = 1'b0;
      m_valid = 1'b0;
      m_rs    = '0;
      m_rt    = '0;
      m_cnt   = 0;
      for (int i = 0; i < NREG; i++) m_regs[i] = '0;
    end else begin
      if (m_valid && bus.op_ready) m_valid = 1'b0;
      if (m_fetch) begin
        m_valid = 1'b1;
        m_rs    = m_f_rs;
        m_rt    = m_f_rt;
        m_fetch = 1'b0;
      end
      if (e_rfire) begin
        m_fetch = 1'b1;
        m_f_rs  = m_regs[bus.rd_rs];
        m_f_rt  = m_regs[bus.rd_rt];
      end
      if (e_rw) m_regs[bus.wb_rd] = bus.wb_data;
      if (e_rfire || (m_cnt == STARVE_LIMIT)) m_cnt = 0;
      else if (bus.rd_valid && e_permit && e_rw && (m_cnt < STARVE_LIMIT)) m_cnt++;
    end

    if (done) begin
      check("timeouts",  tmo_cnt, 0);
      check("responses", lit_rd,  lit_wr);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
    end
  end

  task automatic push(input logic [DATA_W-1:0] rs, input logic [DATA_W-1:0] rt);
    lit_mem[lit_wr] = '{rs: rs, rt: rt};
    lit_wr++;
  endtask

  // Each driver task starts and returns just after a rising edge.
  task automatic do_write(input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
    int n = 0;
    bus.wb_valid = 1'b1;
    bus.wb_rd    = a;
    bus.wb_data  = d;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.wb_ready && n < BUDGET);
    if (!bus.wb_ready) tmo_cnt++;
    @(posedge clk);
    #1;
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
  endtask

  task automatic do_read(input logic [ADDR_W-1:0] rs, input logic [ADDR_W-1:0] rt);
    int n = 0;
    bus.rd_valid = 1'b1;
    bus.rd_rs    = rs;
    bus.rd_rt    = rt;
    do begin
      @(negedge clk);
      n++;
    end while (!bus.rd_ready && n < BUDGET);
    if (!bus.rd_ready) tmo_cnt++;
    @(posedge clk);
    #1;
    bus.rd_valid = 1'b0;
    bus.rd_rs    = '0;
    bus.rd_rt    = '0;
  endtask

  task automatic wait_resp();
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(bus.op_valid && bus.op_ready) && n < BUDGET);
    if (!(bus.op_valid && bus.op_ready)) tmo_cnt++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    bus.wb_valid = 1'b0;
    bus.wb_rd    = '0;
    bus.wb_data  = '0;
    bus.rd_valid = 1'b0;
    bus.rd_rs    = '0;
    bus.rd_rt    = '0;
    bus.op_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(posedge clk);
    #1;

    // Write then read: data appears two cycles after the read accept.
    push(8'h5A, 8'h00);
    do_write(3'd3, 8'h5A);
    do_read(3'd3, 3'd0);
    wait_resp();

    // Same-cycle write and read: write first, read sees new value.
    push(8'h77, 8'h00);
    fork
      do_write(3'd5, 8'h77);
      begin do_read(3'd5, 3'd0); wait_resp(); end
    join

    // Writes to the zero register are dropped.
    push(8'h00, 8'h00);
    do_write(3'd0, 8'hFF);
    do_read(3'd0, 3'd0);
    wait_resp();

    // Continuous writes starve a read until the one-cycle throttle.
    push(8'h11, 8'h15);
    fork
      for (int i = 1; i < NREG; i++) do_write(3'(i), 8'(16 + i));
      begin
        @(posedge clk);
        #1;
        do_read(3'd1, 3'd5);
        wait_resp();
      end
    join

    // Held response stays stable while r2 is rewritten and a new read waits.
    do_write(3'd2, 8'h22);
    push(8'h22, 8'h00);
    push(8'h99, 8'h00);
    bus.op_ready = 1'b0;
    do_read(3'd2, 3'd0);
    fork
      begin repeat (6) @(posedge clk); #1 bus.op_ready = 1'b1; end
      begin do_write(3'd2, 8'h99); do_read(3'd2, 3'd0); wait_resp(); end
    join

    // Reset during FETCH discards the read and clears the file.
    do_read(3'd1, 3'd2);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    push(8'h00, 8'h00);
    do_read(3'd1, 3'd0);
    wait_resp();

    // Back-to-back reads at one per two cycles.
    do_write(3'd4, 8'hA4);
    do_write(3'd6, 8'hB6);
    push(8'hA4, 8'hB6);
    push(8'hB6, 8'hA4);
    do_read(3'd4, 3'd6);
    do_read(3'd6, 3'd4);
    wait_resp();

    repeat (2) @(posedge clk);
    done = 1'b1;
    repeat (5) @(posedge clk);
    $display("FAIL finish: summary not reached (t=%0t)", $time);
    $fatal(1, "bench did not terminate");
  end

endmodule

// File: doc/reg_access_ctrl.md
# reg_access_ctrl

Requester-side controller for the 8-entry, 8-bit register file. Merges a writeback stream and an operand-fetch stream onto the register file's single `rw`/`RS`/`RT`/`RD` port set, and honours the file's rules: a write cycle suppresses reads, and read data arrives one clock after the address. It captures each operand pair and returns it on a valid/ready channel. The block sits between the decode/writeback logic and the register file instance.

## Interface
- `DATA_W`, 8: register data width; must match the register file.
- `ADDR_W`, 3: register address width; address 0 is the hard-zero register.
- `STARVE_LIMIT`, 4: consecutive cycles a pending read may be blocked by writes before writes are throttled.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `wb_valid` in 1, `wb_ready` out 1, `wb_rd` in ADDR_W, `wb_data` in DATA_W: writeback request channel.
- `rd_valid` in 1, `rd_ready` out 1, `rd_rs` in ADDR_W, `rd_rt` in ADDR_W: operand-fetch request channel.
- `op_valid` out 1, `op_ready` in 1, `op_rs_data` out DATA_W, `op_rt_data` out DATA_W: operand response channel.
- `rf_rw` out 1, `rf_rs` out ADDR_W, `rf_rt` out ADDR_W, `rf_rd` out ADDR_W, `rf_rd_data` out DATA_W: drive the register file.
- `rf_rs_data` in DATA_W, `rf_rt_data` in DATA_W: register file read outputs.

## Operation
- States: IDLE (no read in flight), FETCH (read issued last cycle, file outputs valid now), HOLD (result captured, `op_valid`=1).
- Write acceptance: `wb_ready` = !`throttle`. The block accepts in any state. If `wb_rd`≠0, it drives `rf_rw`=1, `rf_rd`=`wb_rd` and `rf_rd_data`=`wb_data` combinationally in the same cycle. A write to `wb_rd`=0 is accepted and dropped, and `rf_rw` stays 0.
- Read acceptance: `rd_ready`=1 only in IDLE, or in HOLD when `op_ready`=1, and only when `rf_rw` is 0 this cycle. On accept, drive `rf_rs`/`rf_rt` from the request and go to FETCH.
- FETCH: capture `rf_rs_data`/`rf_rt_data` into the `op_*` registers at the clock edge, then go to HOLD. Writes are allowed during FETCH.
- HOLD: `op_valid`=1 and data stays stable until `op_ready`. On handshake, go to IDLE, or to FETCH if a new read is accepted the same cycle.
- Starvation counter: increments each cycle `rd_valid`=1, the state permits a read, and the read is blocked by `rf_rw`. It clears on any read accept.
  - When the count reaches STARVE_LIMIT, `throttle`=1 for exactly one cycle: `wb_ready`=0, the read issues, and the counter clears.
- Idle drive: `rf_rw`=0; `rf_rs`, `rf_rt`, `rf_rd` and `rf_rd_data` = 0.
- Ordering: same-cycle write and read means the write goes first and the read issues later and sees the new value. A read accepted the cycle after a write sees the written value.
- Reset: asynchronous. State goes to IDLE, `op_valid`=0, `op_*_data`=0, counter=0, `rf_*`=0, `wb_ready`=`rd_ready`=0 while `reset`=1. Any in-flight read is discarded. `reset` must span at least one `clk` edge so the synchronously reset register file clears too.

## Timing
- Read latency: accept in cycle N, `op_valid` in N+2.
- Read throughput: one read per 2 cycles with `op_ready` held 1.
- Write latency: accept in cycle N, the register file is updated at the end of N.
- `rf_*` outputs are combinational from the accept decision. `op_*` outputs and `wb_ready`'s throttle term are registered.
- No combinational path from `op_ready` to `op_valid`. `rd_ready` depends combinationally on `wb_valid`, `wb_rd` and `op_ready`.

## Structure
- Package `reg_access_pkg`: state enum (IDLE, FETCH, HOLD), `DATA_W`/`ADDR_W` constants, and the `REG_ZERO` address constant.
- Sub-module `reg_access_starve_ctr`: a saturating counter with `inc`, `clr` and `hit` ports, parameterised by STARVE_LIMIT.
- The top level instantiates `reg_access_ctrl` beside the register file, sharing `clk` and `reset`.

## Test plan
- Write r3=0x5A, then read rs=3, rt=0 with `op_ready`=1: `rf_rw` pulses for 1 cycle; `op_valid` appears 2 cycles after the read accept with rs=0x5A, rt=0x00.
- Same-cycle `wb_valid` (r5=0x77) and `rd_valid` (rs=5): the write takes the cycle and `rd_ready`=0; the read accepts next cycle and returns 0x77.
- Write r0=0xFF then read rs=0: `rf_rw` never asserts; the read returns 0x00.
- Continuous `wb_valid` (r1 to r7) with a pending read: after 4 blocked cycles `wb_ready`=0 for one cycle and the read issues; returned data reflects all prior writes.
- `op_ready`=0 for 5 cycles in HOLD while r2 is rewritten: `op_rs_data` holds its original value and `rd_ready`=0 throughout.
- Assert `reset` during FETCH: `op_valid` stays 0 and all `rf_*`=0 immediately. After release, a fresh read of r1 returns 0x00.
